// File: rtl/mc_ctrl_fsm.sv
// Moore main controller for the multicycle ARM datapath.
// Sequences fetch/decode/execute/writeback and counts retired instructions.
module mc_ctrl_fsm #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       Op,
   input  logic [5:0]       Funct,
   output logic             IRWrite,
   output logic             AdrSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ResultSrc,
   output logic             ALUOp,
   output logic             NextPC,
   output logic             RegW,
   output logic             MemW,
   output logic             Branch,
   output logic             Illegal,
   output logic [3:0]       State,
   output logic [CNT_W-1:0] RetireCnt
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_UNKNOWN  = 4'd10
   } state_t;

   state_t state_q;
   state_t state_n;
   logic   retire;
   logic   unused_funct;

   assign unused_funct = ^Funct[4:1];
   assign State        = state_q;

   assign retire = (state_q == S_MEMWB)    ||
                   (state_q == S_MEMWRITE) ||
                   (state_q == S_ALUWB)    ||
                   (state_q == S_BRANCH);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         Illegal   <= 1'b0;
         RetireCnt <= '0;
      end else begin
         state_q   <= state_n;
         Illegal   <= (state_n == S_UNKNOWN);
         if (retire)
            RetireCnt <= RetireCnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_comb begin
      state_n   = S_FETCH;
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 2'd0;
      ALUSrcB   = 2'd0;
      ResultSrc = 2'd0;
      ALUOp     = 1'b0;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            IRWrite   = 1'b1;
            NextPC    = 1'b1;
            ALUSrcA   = 2'd1;
            ALUSrcB   = 2'd2;
            ResultSrc = 2'd2;
            state_n   = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA   = 2'd1;
            ALUSrcB   = 2'd2;
            ResultSrc = 2'd2;
            case (Op)
               2'b01:   state_n = S_MEMADR;
               2'b00:   state_n = Funct[5] ? S_EXECUTEI
                                           : S_EXECUTER;
               2'b10:   state_n = S_BRANCH;
               default: state_n = S_UNKNOWN;
            endcase
         end
         S_MEMADR: begin
            ALUSrcB = 2'd1;
            state_n = Funct[0] ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc  = 1'b1;
            state_n = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = 2'd1;
            RegW      = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            MemW   = 1'b1;
         end
         S_EXECUTER: begin
            ALUOp   = 1'b1;
            state_n = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcB = 2'd1;
            ALUOp   = 1'b1;
            state_n = S_ALUWB;
         end
         S_ALUWB: begin
            RegW = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcB   = 2'd1;
            ResultSrc = 2'd2;
            Branch    = 1'b1;
         end
         // UNKNOWN and undefined codes fall back to FETCH with no controls
         default: state_n = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-cycle state, controls,
// Illegal and RetireCnt checked against a table model.
module tb_mc_ctrl_fsm;

   localparam int W = 4;

   logic         clk;
   logic         reset;
   logic [1:0]   op;
   logic [5:0]   funct;
   logic         irwrite, adrsrc, aluop, nextpc;
   logic         regw, memw, branch, illegal;
   logic [1:0]   alusrca, alusrcb, resultsrc;
   logic [3:0]   state;
   logic [W-1:0] retirecnt;

   typedef struct {
      logic [3:0]   st;
      logic [W-1:0] cnt;
      logic [1:0]   op;
      logic [5:0]   funct;
      bit           hold;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] exp_cnt;
   int           checks;
   int           errors;
   int           cyc;

   mc_ctrl_fsm #(.CNT_W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .Op        (op),
      .Funct     (funct),
      .IRWrite   (irwrite),
      .AdrSrc    (adrsrc),
      .ALUSrcA   (alusrca),
      .ALUSrcB   (alusrcb),
      .ResultSrc (resultsrc),
      .ALUOp     (aluop),
      .NextPC    (nextpc),
      .RegW      (regw),
      .MemW      (memw),
      .Branch    (branch),
      .Illegal   (illegal),
      .State     (state),
      .RetireCnt (retirecnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,NextPC,RegW,MemW,Branch}
   function automatic logic [12:0] ctl_of(input logic [3:0] s);
      logic       ir, adr, aop, npc, rw, mw, br;
      logic [1:0] sa, sb2, rs;
      {ir, adr, aop, npc, rw, mw, br} = '0;
      {sa, sb2, rs} = '0;
      case (s)
         4'd0: begin ir = 1; npc = 1; sa = 1; sb2 = 2; rs = 2; end
         4'd1: begin sa = 1; sb2 = 2; rs = 2; end
         4'd2: sb2 = 1;
         4'd3: adr = 1;
         4'd4: begin rs = 1; rw = 1; end
         4'd5: begin adr = 1; mw = 1; end
         4'd6: aop = 1;
         4'd7: begin sb2 = 1; aop = 1; end
         4'd8: rw = 1;
         4'd9: begin sb2 = 1; rs = 2; br = 1; end
         default: ;
      endcase
      return {ir, adr, sa, sb2, rs, aop, npc, rw, mw, br};
   endfunction

   function automatic logic [12:0] dut_ctl();
      return {irwrite, adrsrc, alusrca, alusrcb, resultsrc,
              aluop, nextpc, regw, memw, branch};
   endfunction

   task automatic push1(input logic [3:0] s, input logic [1:0] o,
                        input logic [5:0] f, input bit h);
      exp_t e;
      e.st = s; e.cnt = exp_cnt; e.op = o; e.funct = f; e.hold = h;
      sb.push_back(e);
   endtask

   task automatic push_instr(input logic [1:0] o, input logic [5:0] f);
      bit ret;
      ret = 1;
      push1(4'd0, o, f, 0);
      push1(4'd1, o, f, 1);
      case (o)
         2'b01: begin
            push1(4'd2, o, f, 1);
            if (f[0]) begin
               push1(4'd3, o, f, 0);
               push1(4'd4, o, f, 0);
            end else begin
               push1(4'd5, o, f, 0);
            end
         end
         2'b00: begin
            push1(f[5] ? 4'd7 : 4'd6, o, f, 0);
            push1(4'd8, o, f, 0);
         end
         2'b10: push1(4'd9, o, f, 0);
         default: begin
            push1(4'd10, o, f, 0);
            ret = 0;
         end
      endcase
      if (ret) exp_cnt = exp_cnt + 1'b1;
   endtask

   // Called at a falling edge with the FSM in FETCH.
   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (state !== e.st) begin
            errors++;
            $display("FAIL state: got %0d exp %0d", state, e.st);
         end
         checks++;
         if (dut_ctl() !== ctl_of(e.st)) begin
            errors++;
            $display("FAIL ctl st%0d: got %b exp %b",
                     e.st, dut_ctl(), ctl_of(e.st));
         end
         checks++;
         if (illegal !== (e.st == 4'd10)) begin
            errors++;
            $display("FAIL illegal st%0d: got %b", e.st, illegal);
         end
         checks++;
         if (retirecnt !== e.cnt) begin
            errors++;
            $display("FAIL retirecnt: got %0d exp %0d", retirecnt, e.cnt);
         end
         if (e.hold) begin
            op = e.op; funct = e.funct;
         end else begin
            op = 2'($urandom); funct = 6'($urandom);
         end
         @(negedge clk);
      end
   endtask

   task automatic run_len(input logic [1:0] o, input logic [5:0] f,
                          input int len, input string nm);
      int c0;
      push_instr(o, f);
      c0 = cyc;
      drain();
      checks++;
      if (cyc - c0 !== len) begin
         errors++;
         $display("FAIL %s cycles: got %0d exp %0d", nm, cyc - c0, len);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; op = 2'b11; funct = '1;
      #2;
      checks++;
      if (state !== 4'd0 || dut_ctl() !== ctl_of(4'd0) ||
          retirecnt !== '0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset: got st%0d ctl %b cnt %0d ill %b",
                  state, dut_ctl(), retirecnt, illegal);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      exp_cnt = '0;
   endtask

   task automatic test_ldr();
      run_len(2'b01, 6'b011001, 5, "ldr");
   endtask

   task automatic test_str();
      run_len(2'b01, 6'b011000, 4, "str");
   endtask

   task automatic test_dp();
      run_len(2'b00, 6'b101000, 4, "dp_imm");
      run_len(2'b00, 6'b001000, 4, "dp_reg");
   endtask

   task automatic test_branch();
      run_len(2'b10, 6'b000000, 3, "b");
   endtask

   task automatic test_illegal();
      logic [W-1:0] c0;
      c0 = retirecnt;
      run_len(2'b11, 6'b010101, 3, "illegal");
      checks++;
      if (retirecnt !== c0) begin
         errors++;
         $display("FAIL illegal_cnt: got %0d exp %0d", retirecnt, c0);
      end
   endtask

   task automatic test_midreset();
      op = 2'b01; funct = 6'b011001;
      repeat (3) @(negedge clk);
      checks++;
      if (state !== 4'd3) begin
         errors++;
         $display("FAIL pre_reset: got %0d exp 3", state);
      end
      checks++;
      if (retirecnt === '0) begin
         errors++;
         $display("FAIL pre_reset_cnt: got 0 exp nonzero");
      end
      #3 reset = 1'b0;
      #1;
      checks++;
      if (state !== 4'd0 || irwrite !== 1'b1 || nextpc !== 1'b1 ||
          retirecnt !== '0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL midreset: got st%0d ir %b npc %b cnt %0d",
                  state, irwrite, nextpc, retirecnt);
      end
      @(negedge clk);
      reset = 1'b1;
      exp_cnt = '0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         run_len(2'b10, 6'($urandom), 3, "b2b");
         if (i == 14) begin
            checks++;
            if (retirecnt !== 4'd15) begin
               errors++;
               $display("FAIL pre_wrap: got %0d exp 15", retirecnt);
            end
         end
      end
      checks++;
      if (retirecnt !== 4'd0) begin
         errors++;
         $display("FAIL wrap: got %0d exp 0", retirecnt);
      end
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0; exp_cnt = '0;
      test_reset();
      test_ldr();
      test_str();
      test_dp();
      test_branch();
      test_illegal();
      test_ldr();
      test_midreset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
